// File: rtl/alu_mdu.sv
// alu_mdu: parametrised integer execute unit for the execute stage.
//
// Single-cycle ALU ops (add/sub/logic/shift/compare) return one cycle after
// acceptance. MUL/MULHU iterate a shift-add multiplier for WIDTH cycles.
// DIV/DIVU/REM/REMU iterate a restoring divider for WIDTH cycles when the
// ALU_DIV_EN macro is defined. Without it, ops 12-15 complete in one cycle
// with result 0 and err 1.
//
// Parameters:
//   WIDTH      operand/result width (power of two, >= 8)
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   operation offered
//   in_ready   unit can accept this cycle
//   op         operation code (0 ADD .. 15 REMU)
//   a, b       operands, captured at accept
//   out_valid  result available, held until consumed
//   out_ready  consumer takes the result this cycle
//   result     result value
//   err        op not supported in this build (qualified by out_valid)
// Build option:
//   ALU_DIV_EN defined -> divider datapath and DIV state are built.

module alu_mdu #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REM   = 4'd14,
    OP_REMU  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  // Shared iteration register: product {hi,lo} for MUL, {remainder,quotient}
  // for DIV (dividend bits shift out of the low half as quotient bits enter).
  logic [2*WIDTH-1:0] r_acc;
  // Multiplicand for MUL, divisor magnitude for DIV.
  logic [WIDTH-1:0]   r_opb;
  // Selects the upper half (MULHU) or remainder (REM/REMU) at completion.
  logic               r_hi_sel;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_err;

  op_e                w_op;
  logic               w_busy;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_done;
  logic               w_load;
  logic               w_wr;
  logic [WIDTH-1:0]   w_wr_res;
  logic               w_wr_err;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_err;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_fin_res;

  assign w_op     = op_e'(op);
  assign w_shamt  = b[SHW-1:0];
  assign w_busy   = (r_state != S_IDLE);
  assign in_ready = !w_busy && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (w_op == OP_MUL) || (w_op == OP_MULHU);
  assign w_done   = w_busy && (r_cnt == '0);

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign err       = r_err;

  // Single-cycle operations. Ops that reach the default arm here are the
  // unsupported ones (divide ops when the divider is not built).
  always_comb begin
    w_alu_res = '0;
    w_alu_err = 1'b0;
    case (w_op)
      OP_ADD:  w_alu_res = a + b;
      OP_SUB:  w_alu_res = a - b;
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_SLL:  w_alu_res = a << w_shamt;
      OP_SRL:  w_alu_res = a >> w_shamt;
      OP_SRA:  w_alu_res = $signed(a) >>> w_shamt;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: w_alu_err = 1'b1;
    endcase
  end

  // Shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (LSB) is set, then shift the whole accumulator right.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opb} : '0);

`ifdef ALU_DIV_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             w_is_div;
  logic             w_sgn_op;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH-1:0] w_div_r;

  assign w_is_div = (op[3:2] == 2'b11);
  // DIV (12) and REM (14) are signed; DIVU (13) and REMU (15) are not.
  assign w_sgn_op = ~op[0];
  assign w_a_neg  = w_sgn_op & a[WIDTH-1];
  assign w_b_neg  = w_sgn_op & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Restoring step: partial remainder shifted left with the next dividend bit.
  // When it fits, the difference is below 2^WIDTH, so the low bits suffice.
  assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_opb});
  assign w_div_diff = w_div_sh[WIDTH-1:0] - r_opb;

  // A zero divisor yields an all-ones quotient regardless of signs; the
  // remainder naturally comes out as the original dividend.
  assign w_div_q = r_dz ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_div_r = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    w_fin_res = '0;
    if (r_state == S_MUL) begin
      w_fin_res = r_hi_sel ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
    end
`ifdef ALU_DIV_EN
    else if (r_state == S_DIV) begin
      w_fin_res = r_hi_sel ? w_div_r : w_div_q;
    end
`endif
  end

  // Next-state and control.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_wr        = 1'b0;
    w_wr_res    = '0;
    w_wr_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_nxt = S_MUL;
            w_load      = 1'b1;
          end
`ifdef ALU_DIV_EN
          else if (w_is_div) begin
            w_state_nxt = S_DIV;
            w_load      = 1'b1;
          end
`endif
          else begin
            w_wr     = 1'b1;
            w_wr_res = w_alu_res;
            w_wr_err = w_alu_err;
          end
        end
      end
      default: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
          w_wr        = 1'b1;
          w_wr_res    = w_fin_res;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opb       <= '0;
      r_hi_sel    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
`ifdef ALU_DIV_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
`endif
    end else begin
      // A fresh result takes priority over consumption of the old one.
      if (w_wr) begin
        r_out_valid <= 1'b1;
        r_result    <= w_wr_res;
        r_err       <= w_wr_err;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_load) begin
        r_cnt    <= CW'(WIDTH);
        r_hi_sel <= w_is_mul ? op[0] : op[1];
        if (w_is_mul) begin
          r_acc <= {{WIDTH{1'b0}}, a};
          r_opb <= b;
        end
`ifdef ALU_DIV_EN
        else begin
          r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
          r_opb   <= w_b_mag;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_dz    <= (b == '0);
        end
`endif
      end else if (w_busy && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_state == S_MUL) begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
        end
`ifdef ALU_DIV_EN
        else begin
          r_acc <= {(w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_div_ge};
        end
`endif
      end
    end
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised integer execute unit: the next-generation ALU, extended with shifts, compares, and multi-cycle multiply/divide.

- Accepts one operation at a time over a valid/ready handshake.
- Single-cycle ops return one cycle after acceptance; multiply/divide iterate for WIDTH cycles.
- The result is held on a valid/ready output until consumed.
- Sits in the execute stage between operand select and writeback.

## Interface
- WIDTH, 64: operand/result width in bits; must be a power of two and ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- op  in  4  operation code (see Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  result value.
- err  out  1  op not supported in this build; qualified by out_valid.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT, 9 SLTU.
  - 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned).
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Arithmetic wraps modulo 2^WIDTH.
- Shifts use b[SHW-1:0] only; SRA replicates a[WIDTH-1].
- SLT/SLTU return 1 or 0, zero-extended to WIDTH.
- Accept = in_valid && in_ready at a rising edge; a, b and op are captured at accept and need not be held afterwards.
- in_ready = !busy && (!out_valid || out_ready), so back-to-back single-cycle ops run at full rate.
- State machine:
  - IDLE: accept of ops 0–9 → writes result, sets out_valid, stays IDLE. Accept of ops 10–15 → loads operands, counter = WIDTH, goes to MUL or DIV.
  - MUL: unsigned shift-add over a 2·WIDTH-bit accumulator, one multiplier bit per cycle.
  - DIV: restoring division on magnitudes, one quotient bit per cycle. Signed ops take magnitudes at load and fix up signs on completion: quotient negated if signs differ; remainder takes the sign of the dividend.
  - MUL/DIV exit: when the counter reaches 0, result and out_valid are written and the state returns to IDLE.
- Output: out_valid stays high and result/err stay stable until out_valid && out_ready; a new result may be written in that same cycle.
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a. These still take the full WIDTH cycles.
- Signed overflow (a = −2^(WIDTH−1), b = −1): DIV = a, REM = 0.
- err = 0 for every supported op.

## Timing
- Reset values: out_valid 0, result 0, err 0, state IDLE, counter 0. in_ready is 1 once reset is released.
- Ops 0–9: accepted at edge N → out_valid high after edge N (latency 1).
- Ops 10–15: accepted at edge N → out_valid high after edge N+WIDTH+1. in_ready is 0 throughout.
- Reset asserted mid-iteration aborts the operation; no result is produced.
- An unconsumed result does not stall an in-flight iteration, but it blocks the next accept.

## Configuration
- ALU_DIV_EN defined: divider datapath, DIV state and sign fix-up are built; ops 12–15 behave as above.
- ALU_DIV_EN undefined: no divider logic. Ops 12–15 complete with latency 1, result = 0 and err = 1. MUL/MULHU are unaffected.

## Test plan
- Reset, then ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 → result 0 one cycle after accept; in_ready stays 1; next op accepted back-to-back.
- SRA a=0x8000_0000_0000_0000, b=0x43 → result 0xF000_0000_0000_0000 (shift 3). SLT a=−1, b=1 → 1. SLTU with the same operands → 0.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE after exactly 65 cycles; in_ready low throughout.
- DIV a=−7, b=2 → −3; REM → −1. DIVU a=5, b=0 → all ones; REMU → 5. DIV a=0x8000_0000_0000_0000, b=−1 → 0x8000_0000_0000_0000.
- Hold out_ready=0 for 5 cycles after a result → result stable, in_ready=0, a pending in_valid is not accepted. Raise out_ready → result consumed and the pending op accepted in the same cycle.
- Assert reset at cycle 30 of a DIV → out_valid 0 and in_ready 1 after release; no stale result ever appears. Repeat with ALU_DIV_EN undefined: DIV → err=1, result 0, latency 1.
